// File: rtl/hsync_decoder_if.sv
// hsync_decoder_if: incoming HSYNC and the timing signals regenerated by hsync_decoder.
// The slave modport is the decoder's view; master is the source/consumer side.
interface hsync_decoder_if;
    logic       hsync_in;
    logic       locked;
    logic       line_start;
    logic       display_en;
    logic [9:0] pixel_x;
    logic       pixel_strobe;
    logic       sync_err;

    modport master (
        output hsync_in,
        input  locked, line_start, display_en, pixel_x, pixel_strobe, sync_err
    );

    modport slave (
        input  hsync_in,
        output locked, line_start, display_en, pixel_x, pixel_strobe, sync_err
    );
endinterface

// File: rtl/hsync_decoder.sv
// hsync_decoder: measures an active-low HSYNC stream, locks to the line timing and regenerates display_en/pixel_x/pixel_strobe.
// Define HSYNC_INPUT_SYNC_EN to pass hsync_in through a 2-flop synchronizer (asynchronous sources).
module hsync_decoder #(
    parameter int SYNC_LEN   = 384,
    parameter int BP_LEN     = 192,
    parameter int DISP_LEN   = 2560,
    parameter int FP_LEN     = 64,
    parameter int TOL        = 4,
    parameter int PIX_DIV    = 4,
    parameter int LOCK_LINES = 2
) (
    input logic            clk,
    input logic            reset,
    hsync_decoder_if.slave bus
);

    typedef enum logic [2:0] {SEARCH, SYNC, BACK, DISP, FRONT} state_t;

    localparam int HIGH_LEN = BP_LEN + DISP_LEN + FP_LEN;
    localparam int PW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int GW       = $clog2(LOCK_LINES + 1);

    localparam logic [11:0]   CNT_MAX   = 12'hfff;
    localparam logic [11:0]   SYNC_MIN  = 12'(SYNC_LEN - TOL);
    localparam logic [11:0]   SYNC_MAX  = 12'(SYNC_LEN + TOL);
    localparam logic [11:0]   HIGH_MIN  = 12'(HIGH_LEN - TOL);
    localparam logic [11:0]   HIGH_MAX  = 12'(HIGH_LEN + TOL);
    localparam logic [11:0]   BP_END    = 12'(BP_LEN);
    localparam logic [11:0]   DISP_END  = 12'(DISP_LEN);
    localparam logic [11:0]   FRONT_MAX = 12'(FP_LEN + TOL);
    localparam logic [9:0]    X_MAX     = 10'(DISP_LEN / PIX_DIV - 1);
    localparam logic [PW-1:0] PHASE_MAX = PW'(PIX_DIV - 1);
    localparam logic [GW-1:0] GOOD_MAX  = GW'(LOCK_LINES);

    logic          hs_src;
    logic          hs;
    logic          hs_prev;
    logic          fall;
    logic          rise;
    state_t        state;
    state_t        state_next;
    logic [11:0]   wcnt;
    logic [11:0]   pcnt;
    logic [11:0]   pcnt_next;
    logic [GW-1:0] good_cnt;
    logic [GW-1:0] good_next;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_next;
    logic [9:0]    pixel_x;
    logic [9:0]    x_next;
    logic          err_next;
    logic          start_next;
    logic          strobe_next;
    logic          in_disp_next;
    logic          locked;
    logic          line_start;
    logic          display_en;
    logic          pixel_strobe;
    logic          sync_err;

`ifdef HSYNC_INPUT_SYNC_EN
    logic sync_1;
    logic sync_2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= bus.hsync_in;
            sync_2 <= sync_1;
        end
    end

    assign hs_src = sync_2;
`else
    assign hs_src = bus.hsync_in;
`endif

    // Reset to the idle-high level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs      <= 1'b1;
            hs_prev <= 1'b1;
        end else begin
            hs      <= hs_src;
            hs_prev <= hs;
        end
    end

    assign fall = hs_prev & ~hs;
    assign rise = ~hs_prev & hs;

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        start_next = 1'b0;
        good_next  = good_cnt;
        case (state)
            SEARCH: begin
                if (fall) state_next = SYNC;
            end
            SYNC: begin
                if (rise) begin
                    if (wcnt >= SYNC_MIN && wcnt <= SYNC_MAX) begin
                        state_next = BACK;
                    end else begin
                        err_next   = 1'b1;
                        state_next = SEARCH;
                    end
                end else if (wcnt > SYNC_MAX) begin
                    err_next   = 1'b1;
                    state_next = SEARCH;
                end
            end
            BACK: begin
                if (fall) begin
                    err_next   = 1'b1;
                    state_next = SYNC;
                end else if (pcnt == BP_END) begin
                    state_next = DISP;
                end
            end
            DISP: begin
                if (fall) begin
                    err_next   = 1'b1;
                    state_next = SYNC;
                end else if (pcnt == DISP_END) begin
                    state_next = FRONT;
                end
            end
            FRONT: begin
                // Checking the fall before the timeout gives the edge priority.
                if (fall) begin
                    state_next = SYNC;
                    if (wcnt >= HIGH_MIN && wcnt <= HIGH_MAX) begin
                        start_next = 1'b1;
                        good_next  = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + GW'(1);
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (pcnt > FRONT_MAX) begin
                    err_next   = 1'b1;
                    state_next = SEARCH;
                end
            end
            default: state_next = SEARCH;
        endcase
        if (err_next) good_next = '0;
    end

    // Pixel outputs are computed from the next state so they line up with the registered state.
    always_comb begin
        pcnt_next    = (state_next != state) ? 12'd1 :
                       ((pcnt == CNT_MAX) ? pcnt : pcnt + 12'd1);
        in_disp_next = (state_next == DISP);
        phase_next   = '0;
        x_next       = '0;
        strobe_next  = 1'b0;
        if (in_disp_next) begin
            if (state == DISP) begin
                phase_next = (phase == PHASE_MAX) ? '0 : phase + PW'(1);
            end
            strobe_next = (phase_next == '0);
            if (state == DISP) begin
                x_next = (strobe_next && pixel_x != X_MAX) ? pixel_x + 10'd1 : pixel_x;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SEARCH;
            wcnt         <= '0;
            pcnt         <= '0;
            good_cnt     <= '0;
            phase        <= '0;
            pixel_x      <= '0;
            locked       <= 1'b0;
            line_start   <= 1'b0;
            display_en   <= 1'b0;
            pixel_strobe <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            state        <= state_next;
            pcnt         <= pcnt_next;
            good_cnt     <= good_next;
            phase        <= phase_next;
            pixel_x      <= x_next;
            locked       <= (good_next == GOOD_MAX);
            line_start   <= start_next;
            display_en   <= in_disp_next & (good_next == GOOD_MAX);
            pixel_strobe <= strobe_next;
            sync_err     <= err_next;
            if (fall || rise) begin
                wcnt <= 12'd1;
            end else if (wcnt != CNT_MAX) begin
                wcnt <= wcnt + 12'd1;
            end
        end
    end

    assign bus.locked       = locked;
    assign bus.line_start   = line_start;
    assign bus.display_en   = display_en;
    assign bus.pixel_x      = pixel_x;
    assign bus.pixel_strobe = pixel_strobe;
    assign bus.sync_err     = sync_err;

endmodule

// File: tb/tb_hsync_decoder.sv
// tb_hsync_decoder: directed HSYNC line patterns; expected line_start/sync_err events are queued
// by the stimulus and checked by an independent monitor together with per-line pixel statistics.
module tb_hsync_decoder;

    typedef struct {
        bit is_err;
        bit locked;
        int strobes;
        int de_cycles;
        int max_x;
        int gap;
    } event_t;

    logic clk = 1'b0;
    logic reset;
    event_t exp_q[$];
    int checks = 0;
    int errors = 0;

    hsync_decoder_if bus ();

    hsync_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_locked"}, int'(bus.locked), 0);
        checkOutput({tag, "_line_start"}, int'(bus.line_start), 0);
        checkOutput({tag, "_display_en"}, int'(bus.display_en), 0);
        checkOutput({tag, "_pixel_x"}, int'(bus.pixel_x), 0);
        checkOutput({tag, "_pixel_strobe"}, int'(bus.pixel_strobe), 0);
        checkOutput({tag, "_sync_err"}, int'(bus.sync_err), 0);
    endtask

    task automatic expectEvent(input bit is_err, input bit lk, input int strobes,
                               input int de_cycles, input int max_x, input int gap);
        event_t e;
        e.is_err    = is_err;
        e.locked    = lk;
        e.strobes   = strobes;
        e.de_cycles = de_cycles;
        e.max_x     = max_x;
        e.gap       = gap;
        exp_q.push_back(e);
    endtask

    // One line starting with a fall; optional one-cycle reset at index rst_at.
    task automatic applyStimulus(input int low, input int high, input int rst_at);
        for (int i = 0; i < low + high; i++) begin
            bus.hsync_in = (i < low) ? 1'b0 : 1'b1;
            if (i == rst_at) begin
                checkOutput("pre_reset_display_en", int'(bus.display_en), 1);
                checkOutput("pre_reset_locked", int'(bus.locked), 1);
                reset = 1'b1;
            end else if (rst_at >= 0 && i == rst_at + 1) begin
                reset = 1'b0;
                checkResetOutputs("mid_reset");
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : monitor
        int cyc = 0;
        int last_ev = -1;
        int strobes = 0;
        int de_cycles = 0;
        int max_x = 0;
        int idx = 0;
        event_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                strobes   = 0;
                de_cycles = 0;
                max_x     = 0;
                last_ev   = -1;
            end else begin
                if (bus.pixel_strobe) strobes++;
                if (bus.display_en) de_cycles++;
                if (int'(bus.pixel_x) > max_x) max_x = int'(bus.pixel_x);
                if (bus.line_start || bus.sync_err) begin
                    if (exp_q.size() == 0) begin
                        checkOutput($sformatf("ev%0d_unexpected", idx), 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput($sformatf("ev%0d_line_start", idx), int'(bus.line_start), int'(!e.is_err));
                        checkOutput($sformatf("ev%0d_sync_err", idx), int'(bus.sync_err), int'(e.is_err));
                        checkOutput($sformatf("ev%0d_locked", idx), int'(bus.locked), int'(e.locked));
                        checkOutput($sformatf("ev%0d_strobes", idx), strobes, e.strobes);
                        checkOutput($sformatf("ev%0d_display_cycles", idx), de_cycles, e.de_cycles);
                        checkOutput($sformatf("ev%0d_max_pixel_x", idx), max_x, e.max_x);
                        checkOutput($sformatf("ev%0d_idle_outputs", idx),
                                    int'({bus.display_en, bus.pixel_strobe, bus.pixel_x}), 0);
                        if (e.gap >= 0) begin
                            checkOutput($sformatf("ev%0d_gap", idx),
                                        (last_ev < 0) ? -1 : cyc - last_ev, e.gap);
                        end
                    end
                    idx++;
                    strobes   = 0;
                    de_cycles = 0;
                    max_x     = 0;
                    last_ev   = cyc;
                end
            end
        end
    end

    initial begin : stimulus
        reset        = 1'b1;
        bus.hsync_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        reset = 1'b0;
        repeat (50) begin
            @(posedge clk);
            #1;
        end

        $display("[TB] ideal stream");
        applyStimulus(384, 2816, -1);
        expectEvent(0, 0, 640, 0, 639, -1);
        applyStimulus(384, 2816, -1);
        expectEvent(0, 1, 640, 0, 639, 3200);
        applyStimulus(384, 2816, -1);
        expectEvent(0, 1, 640, 2560, 639, 3200);
        applyStimulus(384, 2816, -1);

        $display("[TB] short sync pulse and relock");
        expectEvent(0, 1, 640, 2560, 639, 3200);
        expectEvent(1, 0, 0, 0, 0, 300);
        applyStimulus(300, 2900, -1);
        applyStimulus(384, 2816, -1);
        expectEvent(0, 0, 640, 0, 639, 6100);
        applyStimulus(384, 2816, -1);
        expectEvent(0, 1, 640, 0, 639, 3200);

        $display("[TB] extra fall inside display window");
        applyStimulus(384, 1192, -1);
        expectEvent(1, 0, 250, 1000, 249, 1576);
        applyStimulus(384, 2816, -1);
        expectEvent(0, 0, 640, 0, 639, 3200);
        applyStimulus(384, 2816, -1);

        $display("[TB] front porch timeout");
        expectEvent(0, 1, 640, 0, 639, 3200);
        expectEvent(1, 0, 640, 2560, 639, 3205);
        applyStimulus(384, 5000, -1);
        applyStimulus(384, 2816, -1);

        $display("[TB] high width tolerance");
        expectEvent(0, 0, 640, 0, 639, 5379);
        applyStimulus(384, 2818, -1);
        expectEvent(0, 1, 640, 0, 639, 3202);
        applyStimulus(384, 2818, -1);
        expectEvent(0, 1, 640, 2560, 639, 3202);
        applyStimulus(384, 2821, -1);
        expectEvent(1, 0, 640, 2560, 639, 3205);
        applyStimulus(384, 2816, -1);
        expectEvent(0, 0, 640, 0, 639, 3200);
        applyStimulus(384, 2816, -1);

        $display("[TB] reset in display window");
        expectEvent(0, 1, 640, 0, 639, 3200);
        applyStimulus(384, 2816, 1500);
        applyStimulus(384, 2816, -1);
        expectEvent(0, 0, 640, 0, 639, -1);
        applyStimulus(384, 2816, -1);
        expectEvent(0, 1, 640, 0, 639, 3200);

        bus.hsync_in = 1'b0;
        for (int n = 0; n < 500 && exp_q.size() != 0; n++) @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("pending_events", exp_q.size(), 0);
        checkOutput("final_locked", int'(bus.locked), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
